// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline types and constants.
// Used by fetch, decode and the ID/EX register.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int REGW = 5;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] instr;
    logic            valid;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
  } if_id_t;

  function automatic if_id_t mk_if_id(
    input logic [XLEN-1:0] addr,
    input logic [ILEN-1:0] instr,
    input logic            valid
  );
    if_id_t r;
    r.addr  = addr;
    r.instr = instr;
    r.valid = valid;
    r.rs1   = instr[RS1_LSB +: REGW];
    r.rs2   = instr[RS2_LSB +: REGW];
    r.rd    = instr[RD_LSB +: REGW];
    return r;
  endfunction

endpackage

// File: rtl/if_id_fetch_if.sv
// Fetch-stage bus: hazard controls, imem port
// and the IF/ID outputs consumed by decode.
interface if_id_fetch_if;
  import riscv_pkg::*;

  logic            stall;
  logic            flush;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic [XLEN-1:0] Instruction_address_out;
  logic [ILEN-1:0] Instruction_out;
  logic            valid_out;
  logic [REGW-1:0] rs1_out;
  logic [REGW-1:0] rs2_out;
  logic [REGW-1:0] rd_out;

  modport slave (
    input  stall, flush, branch_target, imem_rdata,
    output imem_addr, Instruction_address_out,
    output Instruction_out, valid_out,
    output rs1_out, rs2_out, rd_out
  );

  modport master (
    output stall, flush, branch_target, imem_rdata,
    input  imem_addr, Instruction_address_out,
    input  Instruction_out, valid_out,
    input  rs1_out, rs2_out, rd_out
  );

endinterface

// File: rtl/program_counter.sv
// PC register with next-PC mux.
// Priority: reset > flush > stall > +4.
module program_counter
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset)
      pc <= RESET_PC;
    else if (flush)
      pc <= branch_target;
    else if (!stall)
      pc <= pc + 64'd4;
  end

endmodule

// File: rtl/if_id_fetch.sv
// Fetch stage: owns the PC, drives imem,
// and holds the IF/ID pipeline register.
module if_id_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter logic [ILEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input logic          clk,
  input logic          reset,
  if_id_fetch_if.slave bus
);

  logic [XLEN-1:0] pc;
  if_id_t          q;

  program_counter #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk          (clk),
    .reset        (reset),
    .stall        (bus.stall),
    .flush        (bus.flush),
    .branch_target(bus.branch_target),
    .pc           (pc)
  );

  // Bubble and real entries share one constructor
  always_ff @(posedge clk) begin
    if (!reset)
      q <= mk_if_id('0, NOP_INSTR, 1'b0);
    else if (bus.flush)
      q <= mk_if_id('0, NOP_INSTR, 1'b0);
    else if (!bus.stall)
      q <= mk_if_id(pc, bus.imem_rdata, 1'b1);
  end

  assign bus.imem_addr               = pc;
  assign bus.Instruction_address_out = q.addr;
  assign bus.Instruction_out         = q.instr;
  assign bus.valid_out               = q.valid;
  assign bus.rs1_out                 = q.rs1;
  assign bus.rs2_out                 = q.rs2;
  assign bus.rd_out                  = q.rd;

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed bench for if_id_fetch: reset, advance,
// stall, flush, stall+flush, wrap, reset mid-stall.
module tb_if_id_fetch;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  if_id_fetch_if bus ();

  if_id_fetch #(
    .RESET_PC (64'h0),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h00500093;
    if (a == 64'h4) return 32'h00100113;
    return 32'hA000_0000 | {4'h0, a[27:0]};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [63:0] addr,
                          input logic [31:0] ins,
                          input logic v,
                          input logic [63:0] pc);
    check({tag, ".addr"}, bus.Instruction_address_out, addr);
    check({tag, ".ins"}, 64'(bus.Instruction_out), 64'(ins));
    check({tag, ".valid"}, 64'(bus.valid_out), 64'(v));
    check({tag, ".pc"}, bus.imem_addr, pc);
  endtask

  initial begin
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.branch_target = '0;

    edge1();
    edge1();
    chk_ifid("rst", 64'h0, 32'h13, 1'b0, 64'h0);
    check("rst.rs1", 64'(bus.rs1_out), 64'h0);
    check("rst.rs2", 64'(bus.rs2_out), 64'h0);
    check("rst.rd", 64'(bus.rd_out), 64'h0);

    reset = 1'b1;
    edge1();
    chk_ifid("adv0", 64'h0, 32'h00500093, 1'b1, 64'h4);
    check("adv0.rd", 64'(bus.rd_out), 64'h1);
    edge1();
    chk_ifid("adv1", 64'h4, 32'h00100113, 1'b1, 64'h8);
    check("adv1.rd", 64'(bus.rd_out), 64'h2);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk_ifid("stall", 64'h4, 32'h00100113, 1'b1, 64'h8);
    end
    bus.stall = 1'b0;
    edge1();
    chk_ifid("unstall", 64'h8, 32'hA0000008, 1'b1, 64'hC);

    bus.flush = 1'b1;
    bus.branch_target = 64'h100;
    edge1();
    chk_ifid("flush", 64'h0, 32'h13, 1'b0, 64'h100);
    bus.flush = 1'b0;
    edge1();
    chk_ifid("tgt", 64'h100, 32'hA0000100, 1'b1, 64'h104);

    bus.stall = 1'b1;
    bus.flush = 1'b1;
    bus.branch_target = 64'h40;
    edge1();
    chk_ifid("sflush", 64'h0, 32'h13, 1'b0, 64'h40);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    edge1();
    chk_ifid("stgt", 64'h40, 32'hA0000040, 1'b1, 64'h44);

    bus.flush = 1'b1;
    bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    edge1();
    chk_ifid("wflush", 64'h0, 32'h13, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.flush = 1'b0;
    edge1();
    chk_ifid("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'hAFFFFFFC, 1'b1, 64'h0);
    edge1();
    chk_ifid("post", 64'h0, 32'h00500093, 1'b1, 64'h4);

    bus.stall = 1'b1;
    reset = 1'b0;
    edge1();
    chk_ifid("rstall", 64'h0, 32'h13, 1'b0, 64'h0);
    bus.stall = 1'b0;
    reset = 1'b1;
    edge1();
    chk_ifid("rel", 64'h0, 32'h00500093, 1'b1, 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 1 want 0");
    $fatal(1);
  end

endmodule
